// File: rtl/preadd_pkg.sv
// Shared definitions for the round-robin pre-adder scheduler: defaults, op encoding, S1 entry layout.
package preadd_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 18;
  localparam int IDW_DEF   = $clog2(NREQ_DEF);

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // S1 entry at the default widths; the top rebuilds the same layout for its own parameters.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] in0;
    logic [WIDTH_DEF-1:0] in1;
    logic                 sub;
    logic [IDW_DEF-1:0]   id;
  } s1_entry_t;
endpackage

// File: rtl/preadd_rr_sched_addsub.sv
// Combinational pre-adder/subtracter; result wraps modulo 2^WIDTH.
module preadd_addsub
  import preadd_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);
  assign y = (sub == OP_SUB) ? (a - b) : (a + b);
endmodule

// File: rtl/preadd_rr_sched_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  function automatic int wrap(input int p, input int k);
    return (p + k) % NREQ;
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[wrap(int'(ptr), k)]) begin
        grant[wrap(int'(ptr), k)] = 1'b1;
        idx = IDW'(wrap(int'(ptr), k));
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/preadd_rr_sched.sv
// Round-robin scheduler time-sharing one pre-adder between NREQ requesters; two-stage S1/S2 pipe.
module preadd_rr_sched
  import preadd_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in0,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic [1:0]            in_flight
);
  typedef struct packed {
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             sub;
    logic [IDW-1:0]   id;
  } s1_t;

  logic [IDW-1:0]  rr_ptr;
  logic            s1_valid;
  s1_t             s1;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  g_idx;
  logic            g_any;
  logic            s2_free, s1_load_ok, accept, s1_adv;
  logic [WIDTH-1:0] sum;

  assign s2_free    = !rsp_valid | rsp_ready;
  assign s1_load_ok = !s1_valid | s2_free;
  assign s1_adv     = s1_valid & s2_free;
  assign req_ready  = grant & {NREQ{s1_load_ok}};
  assign accept     = g_any & s1_load_ok;
  assign in_flight  = {1'b0, s1_valid} + {1'b0, rsp_valid};

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  preadd_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (s1.in0),
    .b   (s1.in1),
    .sub (s1.sub),
    .y   (sum)
  );

  // S1 and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1.in0   <= req_in0[g_idx*WIDTH +: WIDTH];
      s1.in1   <= req_in1[g_idx*WIDTH +: WIDTH];
      s1.sub   <= req_sub[g_idx];
      s1.id    <= g_idx;
      rr_ptr   <= (int'(g_idx) == NREQ-1) ? '0 : g_idx + 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: holds stable whenever the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (s2_free) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= sum;
        rsp_id   <= s1.id;
      end
    end
  end
endmodule
